// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling defaults
// used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = OVERSAMPLE / 2 - 1;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous, idle-high input; both flops
// reset to 1 so a held-in-reset line reads as idle.
module uart_rx_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
        end
    end

    assign q_o = sync2_q;

endmodule

// File: rtl/uart_receiver.sv
// Oversampling UART receiver (8N1; 8E1/8O1 when UART_RX_PARITY_EN is defined).
// States: IDLE wait for low line | START mid-start check | DATA shift bits | PARITY capture | STOP sample + publish
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE,
    parameter int PARITY_ODD = 0
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Tick,
    input  logic                 Rx,
    output logic [DATA_BITS-1:0] RxData,
    output logic                 RxDone,
    output logic                 FrameErr,
`ifdef UART_RX_PARITY_EN
    output logic                 ParityErr,
`endif
    output logic                 Busy
);

    localparam int TickW     = $clog2(OVERSAMPLE);
    localparam int BitW      = $clog2(DATA_BITS);
    localparam int MidSample = (OVERSAMPLE == uart_pkg::OVERSAMPLE) ? MID_SAMPLE
                                                                     : OVERSAMPLE / 2 - 1;
    localparam logic [TickW-1:0] TickMid  = TickW'(MidSample);
    localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BITS - 1);

    logic rx_s;

    uart_rx_sync u_sync (
        .clk_i (Clk),
        .rst_i (Rst),
        .d_i   (Rx),
        .q_o   (rx_s)
    );

    uart_state_e            state_q, state_d;
    logic [TickW-1:0]       tick_q, tick_d;
    logic [BitW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   done_q, done_d;
    logic                   ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic                   par_bit_q, par_bit_d;
    logic                   perr_q, perr_d;
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q <= par_bit_d;
            perr_q    <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
        par_bit_d = par_bit_q;
        perr_d    = perr_q;
`endif
        case (state_q)
            // Start detection runs every clock so a start right after a stop is not missed.
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                    tick_d  = '0;
                end
            end
            ST_START: begin
                if (Tick) begin
                    if (tick_q == TickMid) begin
                        if (!rx_s) begin
                            state_d = ST_DATA;
                            tick_d  = '0;
                            bit_d   = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (Tick) begin
                    if (tick_q == TickLast) begin
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        tick_d  = '0;
                        if (bit_q == BitLast) begin
`ifdef UART_RX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (Tick) begin
                    if (tick_q == TickLast) begin
                        par_bit_d = rx_s;
                        tick_d    = '0;
                        state_d   = ST_STOP;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
`endif
            ST_STOP: begin
                if (Tick) begin
                    if (tick_q == TickLast) begin
                        data_d  = shift_q;
                        ferr_d  = ~rx_s;
                        done_d  = 1'b1;
                        tick_d  = '0;
                        state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                        perr_d  = (^shift_q) ^ par_bit_q ^ 1'(PARITY_ODD);
`endif
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign RxData   = data_q;
    assign RxDone   = done_q;
    assign FrameErr = ferr_q;
    assign Busy     = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
    assign ParityErr = perr_q;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: frames are generated from a byte-level
// model, expected results queued, and a monitor checks every RxDone.
module tb_uart_receiver;

    localparam int BIT_CLKS = 64;
    localparam bit PAR_ODD  = 1'b0;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_CLKS = 11 * BIT_CLKS;
`else
    localparam int FRAME_CLKS = 10 * BIT_CLKS;
`endif

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       Tick = 1'b0;
    logic       Rx = 1'b1;
    logic [7:0] RxData;
    logic       RxDone;
    logic       FrameErr;
    logic       Busy;
`ifdef UART_RX_PARITY_EN
    logic       ParityErr;
`endif

    uart_receiver #(
        .DATA_BITS  (8),
        .OVERSAMPLE (16),
        .PARITY_ODD (int'(PAR_ODD))
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Tick     (Tick),
        .Rx       (Rx),
        .RxData   (RxData),
        .RxDone   (RxDone),
        .FrameErr (FrameErr),
`ifdef UART_RX_PARITY_EN
        .ParityErr(ParityErr),
`endif
        .Busy     (Busy)
    );

    always #5 Clk = ~Clk;

    logic [1:0] tick_div = 2'd0;
    always @(posedge Clk) begin
        tick_div <= tick_div + 2'd1;
        Tick     <= (tick_div == 2'd3);
    end

    int cyc = 0;
    always @(posedge Clk) cyc++;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    exp_t exp_q[$];
    int   done_times[$];
    int   n_pass = 0;
    int   n_chk  = 0;
    logic prev_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // Monitor: every RxDone must match the oldest queued frame and last one cycle.
    always @(negedge Clk) begin
        if (RxDone) begin
            check("done_one_cycle", {31'd0, prev_done}, 32'd0);
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_done: RxDone=1 with data %0h, expected no strobe (cycle %0d)", RxData, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rx_data", {24'd0, RxData}, {24'd0, e.data});
                check("frame_err", {31'd0, FrameErr}, {31'd0, e.ferr});
`ifdef UART_RX_PARITY_EN
                check("parity_err", {31'd0, ParityErr}, {31'd0, e.perr});
`endif
            end
            done_times.push_back(cyc);
        end
        prev_done = RxDone;
    end

    // Line-level frame generator; the expected result comes from the byte
    // and the deliberately corrupted fields, not from the receiver's sampling.
    task automatic send_frame(input logic [7:0] data, input bit bad_stop, input bit bad_par);
        exp_t e;
        e.data = data;
        e.ferr = bad_stop;
        e.perr = bad_par;
        exp_q.push_back(e);
        Rx = 1'b0;
        hold(2);
        check("busy_latency_lo", {31'd0, Busy}, 32'd0);
        hold(1);
        check("busy_latency_hi", {31'd0, Busy}, 32'd1);
        hold(BIT_CLKS - 3);
        for (int i = 0; i < 8; i++) begin
            Rx = data[i];
            hold(BIT_CLKS);
        end
`ifdef UART_RX_PARITY_EN
        Rx = (^data) ^ PAR_ODD ^ bad_par;
        hold(BIT_CLKS);
`endif
        if (bad_stop) begin
            // Low across the stop sample point, released before the re-armed start check.
            Rx = 1'b0;
            hold(44);
            Rx = 1'b1;
            hold(BIT_CLKS - 44);
        end else begin
            Rx = 1'b1;
            hold(BIT_CLKS);
        end
        check("done_seen", exp_q.size(), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] d;
        bit         bs;
        bit         bp;
        int         n;

        Rst = 1'b1;
        Rx  = 1'b1;
        hold(3);
        check("reset_rxdata", {24'd0, RxData}, 32'd0);
        check("reset_rxdone", {31'd0, RxDone}, 32'd0);
        check("reset_frameerr", {31'd0, FrameErr}, 32'd0);
        check("reset_busy", {31'd0, Busy}, 32'd0);
`ifdef UART_RX_PARITY_EN
        check("reset_parityerr", {31'd0, ParityErr}, 32'd0);
`endif
        Rst = 1'b0;
        hold(10);

        send_frame(8'hA5, 1'b0, 1'b0);
        check("busy_after_stop", {31'd0, Busy}, 32'd0);
        hold(20);

        // Glitch shorter than half a bit: must fall back to IDLE silently.
        Rx = 1'b0;
        hold(12);
        Rx = 1'b1;
        hold(80);
        check("busy_after_glitch", {31'd0, Busy}, 32'd0);

        send_frame(8'h00, 1'b1, 1'b0);
        hold(BIT_CLKS);
        send_frame(8'h5A, 1'b0, 1'b0);
        hold(30);

        send_frame(8'h55, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b0, 1'b0);
        n = done_times.size();
        if (n >= 2) check("b2b_spacing", 32'(done_times[n-1] - done_times[n-2]), 32'(FRAME_CLKS));
        else check("b2b_done_count", 32'(n), 32'd2);
        hold(30);

        // Abort 0x81 after four data bits with a one-cycle reset.
        Rx = 1'b0;
        hold(BIT_CLKS);
        d = 8'h81;
        for (int i = 0; i < 4; i++) begin
            Rx = d[i];
            hold(BIT_CLKS);
        end
        Rst = 1'b1;
        Rx  = 1'b1;
        hold(1);
        check("midreset_rxdata", {24'd0, RxData}, 32'd0);
        check("midreset_rxdone", {31'd0, RxDone}, 32'd0);
        check("midreset_frameerr", {31'd0, FrameErr}, 32'd0);
        check("midreset_busy", {31'd0, Busy}, 32'd0);
        Rst = 1'b0;
        hold(1);
        check("ready_after_reset", {31'd0, Busy}, 32'd0);
        hold(BIT_CLKS);
        send_frame(8'h3C, 1'b0, 1'b0);
        hold(20);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b0, 1'b0);
        hold(20);
        send_frame(8'h07, 1'b0, 1'b1);
        hold(20);
`endif

        for (int k = 0; k < 16; k++) begin
            d  = 8'($urandom);
            bs = ($urandom_range(3) == 0);
`ifdef UART_RX_PARITY_EN
            bp = ($urandom_range(2) == 0);
`else
            bp = 1'b0;
`endif
            send_frame(d, bs, bp);
            if (bs) hold(BIT_CLKS + int'($urandom_range(20)));
            else hold(int'($urandom_range(40)));
        end

        hold(100);
        check("queue_drained", exp_q.size(), 32'd0);
        check("final_busy", {31'd0, Busy}, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
